// File: rtl/multicycle_control_fsm_if.sv
// Memory port bundle between the multicycle control unit and the
// instruction/data memory.
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit for the RV32I core. The memory handshake has a
// bounded wait. Illegal opcodes and bus timeouts park the FSM in a sticky
// TRAP state until reset.
module multicycle_control_fsm #(
  parameter int TIMEOUT_W      = 8,
  parameter int TIMEOUT_CYCLES = 200,
  parameter bit HAS_U          = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_control_fsm_if.master bus,
  input  logic [6:0]              opcode,
  input  logic                    zero_flag,
  output logic                    ir_write,
  output logic                    reg_write,
  output logic                    pc_update,
  output logic                    branch,
  output logic                    pc_src,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [2:0]              alu_op,
  output logic [1:0]              result_src,
  output logic [3:0]              fsm_state,
  output logic                    illegal_instr,
  output logic                    bus_fault
);

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_EXECUTER   = 4'd2,
    S_UNCONDJUMP = 4'd3,
    S_EXECUTEI   = 4'd4,
    S_MEMADR     = 4'd5,
    S_ALUWB      = 4'd6,
    S_MEMWRITE   = 4'd7,
    S_MEMREAD    = 4'd8,
    S_MEMWB      = 4'd9,
    S_BRANCHIFEQ = 4'd10,
    S_JALR_ADDR  = 4'd11,
    S_JALR_LINK  = 4'd12,
    S_LUI        = 4'd13,
    S_AUIPC      = 4'd14,
    S_TRAP       = 4'd15
  } state_t;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // Compare value for the last permitted wait cycle; unused when the timeout is disabled.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WAIT_MAX = '1;

  state_t               state, state_next;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 waiting, timeout, set_ill;
  logic                 mem_req, mem_write, adr_src;

  assign bus.mem_req   = mem_req;
  assign bus.mem_write = mem_write;
  assign bus.adr_src   = adr_src;
  assign fsm_state     = state;

  // A wait cycle is a memory-requesting state whose request is not accepted yet.
  assign waiting = ((state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE))
                   && !bus.mem_ready;
  assign timeout = (TIMEOUT_CYCLES != 0) && waiting && (wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Wait counter: restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               wait_cnt <= '0;
    else if (state_next != state)            wait_cnt <= '0;
    else if (waiting && wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + TIMEOUT_W'(1);
  end

  // Sticky trap causes, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_instr <= 1'b0;
      bus_fault     <= 1'b0;
    end else begin
      if (set_ill) illegal_instr <= 1'b1;
      if (timeout) bus_fault     <= 1'b1;
    end
  end

  // Next-state and control outputs; every output is zero unless the state claims it.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    result_src = 2'b00;
    set_ill    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          pc_update  = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OPC_R:               state_next = S_EXECUTER;
          OPC_I:               state_next = S_EXECUTEI;
          OPC_LOAD, OPC_STORE: state_next = S_MEMADR;
          OPC_BR:              state_next = S_BRANCHIFEQ;
          OPC_JAL:             state_next = S_UNCONDJUMP;
          OPC_JALR:            state_next = S_JALR_ADDR;
          OPC_LUI:             state_next = HAS_U ? S_LUI : S_TRAP;
          OPC_AUIPC:           state_next = HAS_U ? S_AUIPC : S_TRAP;
          default:             state_next = S_TRAP;
        endcase
        set_ill = (state_next == S_TRAP);
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10; alu_src_b = 2'b00; alu_op = 3'b010;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 3'b011;
        state_next = S_ALUWB;
      end
      S_UNCONDJUMP: begin
        alu_src_a = 2'b01; alu_src_b = 2'b10; pc_update = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR_ADDR: begin
        alu_src_a = 2'b10; alu_src_b = 2'b01; result_src = 2'b10; pc_update = 1'b1;
        state_next = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        alu_src_a = 2'b01; alu_src_b = 2'b10;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        alu_src_b = 2'b01; alu_op = 3'b100;
        state_next = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01; alu_src_b = 2'b01;
        state_next = S_ALUWB;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10; alu_src_b = 2'b01;
        state_next = (opcode == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1; adr_src = 1'b1;
        if (bus.mem_ready) state_next = S_MEMWB;
        else if (timeout)  state_next = S_TRAP;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1; mem_write = 1'b1; adr_src = 1'b1;
        if (bus.mem_ready) state_next = S_FETCH;
        else if (timeout)  state_next = S_TRAP;
      end
      S_MEMWB: begin
        result_src = 2'b01; reg_write = 1'b1;
        state_next = S_FETCH;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCHIFEQ: begin
        alu_src_a = 2'b10; alu_src_b = 2'b00; alu_op = 3'b001;
        branch = 1'b1; pc_update = 1'b1; pc_src = zero_flag;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
    endcase
  end

endmodule
